// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
package reg_file_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 8;
    localparam int RF_NUM_RD = 2;

    // Address width never drops below one bit, even for DEPTH <= 2.
    function automatic int rf_aw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One asynchronous read port: array mux, out-of-range zeroing and the
// optional same-cycle write bypass (REGFILE_BYPASS_EN).
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = rf_aw(DEPTH)
) (
    input  logic             rst_n,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    input  logic             w_enable_0,
    input  logic [AW-1:0]    w_addr_0,
    input  logic [WIDTH-1:0] w_data_0,
    input  logic             w_enable_1,
    input  logic [AW-1:0]    w_addr_1,
    input  logic [WIDTH-1:0] w_data_1,
    output logic [WIDTH-1:0] val,
    output logic             val_busy
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic in_range;
    assign in_range = ({1'b0, addr} < DEPTH_LIM);

    always_comb begin
        val      = '0;
        val_busy = 1'b0;
        if (in_range) begin
            val_busy = busy[addr];
        end
        if (rst_n && in_range) begin
            val = regs[addr];
`ifdef REGFILE_BYPASS_EN
            // An in-range read address matching a write implies the write is in range too.
            if (w_enable_0 && (w_addr_0 == addr)) val = w_data_0;
            if (w_enable_1 && (w_addr_1 == addr)) val = w_data_1;
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{w_enable_0, w_addr_0, w_data_0, w_enable_1, w_addr_1, w_data_1};
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async reads, two sync write ports and a
// busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int AW     = rf_aw(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD*AW-1:0]    r_addr,
    output logic [NUM_RD*WIDTH-1:0] r_val,
    output logic [NUM_RD-1:0]       r_busy,
    input  logic                    w_enable_0,
    input  logic [AW-1:0]           w_addr_0,
    input  logic [WIDTH-1:0]        w_data_0,
    input  logic                    w_enable_1,
    input  logic [AW-1:0]           w_addr_1,
    input  logic [WIDTH-1:0]        w_data_1,
    input  logic                    rsv_enable,
    input  logic [AW-1:0]           rsv_addr,
    output logic [DEPTH-1:0]        busy
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic w0_ok, w1_ok, rsv_ok;

    assign w0_ok  = w_enable_0 && ({1'b0, w_addr_0} < DEPTH_LIM);
    assign w1_ok  = w_enable_1 && ({1'b0, w_addr_1} < DEPTH_LIM);
    assign rsv_ok = rsv_enable && ({1'b0, rsv_addr} < DEPTH_LIM);

    // Statement order encodes priority: port 1 over port 0, reserve over write-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            if (w0_ok)  regs[w_addr_0] <= w_data_0;
            if (w1_ok)  regs[w_addr_1] <= w_data_1;
            if (w0_ok)  busy[w_addr_0] <= 1'b0;
            if (w1_ok)  busy[w_addr_1] <= 1'b0;
            if (rsv_ok) busy[rsv_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_rd_port #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH),
            .AW   (AW)
        ) u_rd (
            .rst_n     (rst_n),
            .addr      (r_addr[k*AW +: AW]),
            .regs      (regs),
            .busy      (busy),
            .w_enable_0(w_enable_0),
            .w_addr_0  (w_addr_0),
            .w_data_0  (w_data_0),
            .w_enable_1(w_enable_1),
            .w_addr_1  (w_addr_1),
            .w_data_1  (w_data_1),
            .val       (r_val[k*WIDTH +: WIDTH]),
            .val_busy  (r_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized checks for reg_file_mp in default, DEPTH=6 and
// NUM_RD=4/WIDTH=64 configurations.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int errors = 0;
    int checks = 0;

    // Default configuration
    logic [5:0]  r_addr;
    logic [63:0] r_val;
    logic [1:0]  r_busy;
    logic        w_en0, w_en1, rsv_en;
    logic [2:0]  w_addr0, w_addr1, rsv_addr;
    logic [31:0] w_data0, w_data1;
    logic [7:0]  busy;

    reg_file_mp dut (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_val(r_val), .r_busy(r_busy),
        .w_enable_0(w_en0), .w_addr_0(w_addr0), .w_data_0(w_data0),
        .w_enable_1(w_en1), .w_addr_1(w_addr1), .w_data_1(w_data1),
        .rsv_enable(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
    );

    // DEPTH = 6
    logic [5:0]  s_r_addr;
    logic [63:0] s_r_val;
    logic [1:0]  s_r_busy;
    logic        s_w_en0, s_w_en1, s_rsv_en;
    logic [2:0]  s_w_addr0, s_w_addr1, s_rsv_addr;
    logic [31:0] s_w_data0, s_w_data1;
    logic [5:0]  s_busy;

    reg_file_mp #(.DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .r_addr(s_r_addr), .r_val(s_r_val), .r_busy(s_r_busy),
        .w_enable_0(s_w_en0), .w_addr_0(s_w_addr0), .w_data_0(s_w_data0),
        .w_enable_1(s_w_en1), .w_addr_1(s_w_addr1), .w_data_1(s_w_data1),
        .rsv_enable(s_rsv_en), .rsv_addr(s_rsv_addr), .busy(s_busy)
    );

    // NUM_RD = 4, WIDTH = 64
    logic [11:0]  m_r_addr;
    logic [255:0] m_r_val;
    logic [3:0]   m_r_busy;
    logic         m_w_en0, m_w_en1, m_rsv_en;
    logic [2:0]   m_w_addr0, m_w_addr1, m_rsv_addr;
    logic [63:0]  m_w_data0, m_w_data1;
    logic [7:0]   m_busy;

    reg_file_mp #(.NUM_RD(4), .WIDTH(64)) dutw (
        .clk(clk), .rst_n(rst_n), .r_addr(m_r_addr), .r_val(m_r_val), .r_busy(m_r_busy),
        .w_enable_0(m_w_en0), .w_addr_0(m_w_addr0), .w_data_0(m_w_data0),
        .w_enable_1(m_w_en1), .w_addr_1(m_w_addr1), .w_data_1(m_w_data1),
        .rsv_enable(m_rsv_en), .rsv_addr(m_rsv_addr), .busy(m_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_en0 = 0; w_en1 = 0; rsv_en = 0;
        w_addr0 = '0; w_addr1 = '0; rsv_addr = '0; w_data0 = '0; w_data1 = '0;
        s_w_en0 = 0; s_w_en1 = 0; s_rsv_en = 0;
        s_w_addr0 = '0; s_w_addr1 = '0; s_rsv_addr = '0; s_w_data0 = '0; s_w_data1 = '0;
        m_w_en0 = 0; m_w_en1 = 0; m_rsv_en = 0;
        m_w_addr0 = '0; m_w_addr1 = '0; m_rsv_addr = '0; m_w_data0 = '0; m_w_data1 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1;
        idle();
        for (int i = 0; i < 4; i++) begin
            w_en0 = 1; w_addr0 = 3'(2 * i);     w_data0 = 32'hFFFF_FFFF;
            w_en1 = 1; w_addr1 = 3'(2 * i + 1); w_data1 = 32'hFFFF_FFFF;
            tick();
        end
        idle();
        rsv_en = 1; rsv_addr = 3'd3;
        tick();
        idle();
        r_addr = {3'd7, 3'd0};
        #1;
        checks++;
        if (busy !== 8'h08) begin
            errors++; $display("FAIL reset_pre_busy: got %h expected %h", busy, 8'h08);
        end
        checks++;
        if (r_val !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL reset_pre_val: got %h expected all ones", r_val);
        end
        // Reset cycle with a write and a reserve that must both be ignored
        rst_n = 0;
        w_en0 = 1; w_addr0 = 3'd0; w_data0 = 32'h0000_0005;
        rsv_en = 1; rsv_addr = 3'd0;
        r_addr = {3'd0, 3'd0};
        #1;
        checks++;
        if (r_val !== 64'h0) begin
            errors++; $display("FAIL reset_during_val: got %h expected 0", r_val);
        end
        tick();
        idle();
        rst_n = 1;
        #1;
        checks++;
        if (busy !== 8'h00) begin
            errors++; $display("FAIL reset_busy: got %h expected 00", busy);
        end
        for (int a = 0; a < 8; a++) begin
            r_addr = {3'(a), 3'(a)};
            #1;
            checks++;
            if (r_val !== 64'h0 || r_busy !== 2'b00) begin
                errors++;
                $display("FAIL reset_reg%0d: got val %h busy %b expected 0 0", a, r_val, r_busy);
            end
        end
    endtask

    task automatic test_dual_write();
        w_en0 = 1; w_addr0 = 3'd2; w_data0 = 32'h1111_1111;
        w_en1 = 1; w_addr1 = 3'd5; w_data1 = 32'h2222_2222;
        tick();
        idle();
        r_addr = {3'd5, 3'd2};
        #1;
        checks++;
        if (r_val[31:0] !== 32'h1111_1111) begin
            errors++; $display("FAIL dual_r2: got %h expected 11111111", r_val[31:0]);
        end
        checks++;
        if (r_val[63:32] !== 32'h2222_2222) begin
            errors++; $display("FAIL dual_r5: got %h expected 22222222", r_val[63:32]);
        end
    endtask

    task automatic test_collision();
        w_en0 = 1; w_addr0 = 3'd4; w_data0 = 32'hAAAA_0000;
        w_en1 = 1; w_addr1 = 3'd4; w_data1 = 32'h0000_BBBB;
        tick();
        idle();
        r_addr = {3'd4, 3'd4};
        #1;
        checks++;
        if (r_val !== {32'h0000_BBBB, 32'h0000_BBBB}) begin
            errors++; $display("FAIL collision_r4: got %h expected 0000bbbb on both", r_val);
        end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 3'd6;
        tick();
        idle();
        r_addr = {3'd0, 3'd6};
        #1;
        checks++;
        if (busy !== 8'h40) begin
            errors++; $display("FAIL sb_reserve_busy: got %h expected 40", busy);
        end
        checks++;
        if (r_busy !== 2'b01) begin
            errors++; $display("FAIL sb_reserve_rbusy: got %b expected 01", r_busy);
        end
        w_en0 = 1; w_addr0 = 3'd6; w_data0 = 32'h0000_0066;
        rsv_en = 1; rsv_addr = 3'd6;
        tick();
        idle();
        checks++;
        if (busy !== 8'h40) begin
            errors++; $display("FAIL sb_write_rsv_busy: got %h expected 40", busy);
        end
        checks++;
        if (r_val[31:0] !== 32'h0000_0066) begin
            errors++; $display("FAIL sb_write_rsv_val: got %h expected 00000066", r_val[31:0]);
        end
        rsv_en = 1; rsv_addr = 3'd6;
        tick();
        idle();
        checks++;
        if (busy !== 8'h40) begin
            errors++; $display("FAIL sb_rsv_again: got %h expected 40", busy);
        end
        w_en1 = 1; w_addr1 = 3'd6; w_data1 = 32'h0000_0077;
        tick();
        idle();
        checks++;
        if (busy !== 8'h00 || r_busy !== 2'b00) begin
            errors++; $display("FAIL sb_write_clear: got busy %h rbusy %b expected 00 00", busy, r_busy);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic [31:0] exp_prio;
        w_en0 = 1; w_addr0 = 3'd1; w_data0 = 32'h1234_5678;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEAD_BEEF;
        exp_prio = 32'h0BAD_F00D;
`else
        exp_same = 32'h1234_5678;
        exp_prio = 32'h1234_5678;
`endif
        r_addr = {3'd1, 3'd1};
        w_en0 = 1; w_addr0 = 3'd1; w_data0 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (r_val !== {exp_same, exp_same}) begin
            errors++; $display("FAIL bypass_same_cycle: got %h expected %h on both", r_val, exp_same);
        end
        w_en1 = 1; w_addr1 = 3'd1; w_data1 = 32'h0BAD_F00D;
        #1;
        checks++;
        if (r_val !== {exp_prio, exp_prio}) begin
            errors++; $display("FAIL bypass_priority: got %h expected %h on both", r_val, exp_prio);
        end
        w_en1 = 0;
        tick();
        idle();
        checks++;
        if (r_val !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL bypass_after_edge: got %h expected deadbeef on both", r_val);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 3; i++) begin
            s_w_en0 = 1; s_w_addr0 = 3'(2 * i);     s_w_data0 = 32'h1000_0000 + 32'(2 * i);
            s_w_en1 = 1; s_w_addr1 = 3'(2 * i + 1); s_w_data1 = 32'h1000_0000 + 32'(2 * i + 1);
            tick();
        end
        idle();
        s_rsv_en = 1; s_rsv_addr = 3'd5;
        tick();
        idle();
        s_w_en0 = 1; s_w_addr0 = 3'd7; s_w_data0 = 32'hDEAD_0007;
        s_w_en1 = 1; s_w_addr1 = 3'd6; s_w_data1 = 32'hDEAD_0006;
        s_rsv_en = 1; s_rsv_addr = 3'd6;
        s_r_addr = {3'd7, 3'd6};
        #1;
        checks++;
        if (s_r_val !== 64'h0 || s_r_busy !== 2'b00) begin
            errors++; $display("FAIL oor_read: got val %h busy %b expected 0 00", s_r_val, s_r_busy);
        end
        tick();
        idle();
        checks++;
        if (s_busy !== 6'b100000) begin
            errors++; $display("FAIL oor_busy: got %b expected 100000", s_busy);
        end
        for (int a = 0; a < 6; a++) begin
            s_r_addr = {3'(a), 3'(a)};
            #1;
            checks++;
            if (s_r_val[31:0] !== 32'h1000_0000 + 32'(a)) begin
                errors++;
                $display("FAIL oor_reg%0d: got %h expected %h", a, s_r_val[31:0], 32'h1000_0000 + 32'(a));
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] mem [8];
        logic [7:0]  mbusy;
        logic [63:0] exp_v;
        logic [2:0]  a;
        rst_n = 0;
        idle();
        tick();
        rst_n = 1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mbusy = '0;
        for (int c = 0; c < 10000; c++) begin
            m_w_en0 = 1'($urandom_range(0, 1)); m_w_addr0 = 3'($urandom_range(0, 7));
            m_w_data0 = {$urandom, $urandom};
            m_w_en1 = 1'($urandom_range(0, 1)); m_w_addr1 = 3'($urandom_range(0, 7));
            m_w_data1 = {$urandom, $urandom};
            m_rsv_en = 1'($urandom_range(0, 1)); m_rsv_addr = 3'($urandom_range(0, 7));
            m_r_addr = 12'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                a = m_r_addr[k*3 +: 3];
                exp_v = mem[a];
`ifdef REGFILE_BYPASS_EN
                if (m_w_en0 && m_w_addr0 == a) exp_v = m_w_data0;
                if (m_w_en1 && m_w_addr1 == a) exp_v = m_w_data1;
`endif
                checks++;
                if (m_r_val[k*64 +: 64] !== exp_v || m_r_busy[k] !== mbusy[a]) begin
                    errors++;
                    $display("FAIL rand_c%0d_p%0d: got val %h busy %b expected %h %b",
                             c, k, m_r_val[k*64 +: 64], m_r_busy[k], exp_v, mbusy[a]);
                end
            end
            checks++;
            if (m_busy !== mbusy) begin
                errors++; $display("FAIL rand_c%0d_busy: got %h expected %h", c, m_busy, mbusy);
            end
            @(posedge clk);
            if (m_w_en0) mem[m_w_addr0] = m_w_data0;
            if (m_w_en1) mem[m_w_addr1] = m_w_data1;
            if (m_w_en0) mbusy[m_w_addr0] = 1'b0;
            if (m_w_en1) mbusy[m_w_addr1] = 1'b0;
            if (m_rsv_en) mbusy[m_rsv_addr] = 1'b1;
            #1;
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        r_addr = '0; s_r_addr = '0; m_r_addr = '0;
        tick();
        test_reset();
        test_dual_write();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
